spi_byte_sequencer: RTL

SPI_BYTE_SEQUENCER -- requirements
Module: spi_byte_sequencer

---
 rtl/spi_byte_sequencer_if.sv | 33 +++
 rtl/spi_byte_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_sequencer_if.sv
// Host and SPI-master facing signal bundle for spi_byte_sequencer.
// slave: the sequencer side. master: the host/SPI-master side.
interface spi_byte_sequencer_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          spi_enable;
    logic [7:0]    spi_data_in;
    logic          spi_cs;
    logic [7:0]    spi_data_out;
    logic          busy;
    logic          timeout_err;
    logic [LW-1:0] tx_level;

    modport slave (
        input  tx_valid, tx_data, rx_ready, spi_cs, spi_data_out,
        output tx_ready, rx_valid, rx_data, spi_enable, spi_data_in,
               busy, timeout_err, tx_level
    );

    modport master (
        output tx_valid, tx_data, rx_ready, spi_cs, spi_data_out,
        input  tx_ready, rx_valid, rx_data, spi_enable, spi_data_in,
               busy, timeout_err, tx_level
    );
endinterface

// File: rtl/spi_byte_sequencer.sv
// Byte sequencer feeding an SPI master from a TX FIFO and collecting the
// returned bytes into RX storage. One byte in flight at a time.
// Build option: SPI_SEQ_RX_FIFO_EN selects a DEPTH-entry RX FIFO; otherwise
// RX storage is a single holding register.
module spi_byte_sequencer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_byte_sequencer_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARM, XFER, CAPTURE} state_t;

    state_t        state, state_nxt;
    logic          start_c, capture_c, timeout_c;
    logic          tx_push, rx_pop, rx_free, rx_valid_int;

    logic [7:0]    tx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [LW-1:0] tx_level;
    logic [CW-1:0] wait_cnt;
    logic [7:0]    data_in_q;
    logic          enable_q, busy_q, timeout_q;

    assign tx_push = bus.tx_valid && bus.tx_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and per-cycle control strobes; cs low beats the timeout.
    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        capture_c = 1'b0;
        timeout_c = 1'b0;
        case (state)
            IDLE: begin
                if (tx_level != '0 && rx_free) begin
                    state_nxt = ARM;
                    start_c   = 1'b1;
                end
            end
            ARM: begin
                if (!bus.spi_cs) begin
                    state_nxt = XFER;
                end else if (wait_cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    timeout_c = 1'b1;
                end
            end
            XFER: begin
                if (bus.spi_cs) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                capture_c = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Cycles spent waiting in ARM for chip select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  wait_cnt <= '0;
        else if (state == ARM && state_nxt == ARM)  wait_cnt <= wait_cnt + CW'(1);
        else                                        wait_cnt <= '0;
    end

    // TX FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_level  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
            if (start_c) tx_rd_ptr <= tx_rd_ptr + AW'(1);
            case ({tx_push, start_c})
                2'b10:   tx_level <= tx_level + LW'(1);
                2'b01:   tx_level <= tx_level - LW'(1);
                default: tx_level <= tx_level;
            endcase
        end
    end

    // TX FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.tx_data;
    end

    // Byte to the master changes only when a transfer is launched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        data_in_q <= 8'h00;
        else if (start_c) data_in_q <= tx_mem[tx_rd_ptr];
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            enable_q  <= (state_nxt == ARM);
            busy_q    <= (state_nxt != IDLE);
            timeout_q <= timeout_c;
        end
    end

`ifdef SPI_SEQ_RX_FIFO_EN
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [LW-1:0] rx_count;

    assign rx_valid_int = (rx_count != '0);
    assign rx_pop       = rx_valid_int && bus.rx_ready;
    assign rx_free      = (rx_count != LW'(DEPTH)) || rx_pop;
    assign bus.rx_data  = rx_valid_int ? rx_mem[rx_rd_ptr] : 8'h00;

    // RX FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
        end else begin
            if (capture_c) rx_wr_ptr <= rx_wr_ptr + AW'(1);
            if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + AW'(1);
            case ({capture_c, rx_pop})
                2'b10:   rx_count <= rx_count + LW'(1);
                2'b01:   rx_count <= rx_count - LW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // RX FIFO storage.
    always_ff @(posedge clk) begin
        if (capture_c) rx_mem[rx_wr_ptr] <= bus.spi_data_out;
    end
`else
    logic [7:0] rx_reg;
    logic       rx_full;

    assign rx_valid_int = rx_full;
    assign rx_pop       = rx_full && bus.rx_ready;
    assign rx_free      = !rx_full || rx_pop;
    assign bus.rx_data  = rx_reg;

    // Single RX holding register; a launch is only allowed when it will be free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_reg  <= 8'h00;
            rx_full <= 1'b0;
        end else if (capture_c) begin
            rx_reg  <= bus.spi_data_out;
            rx_full <= 1'b1;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end
    end
`endif

    assign bus.rx_valid    = rx_valid_int;
    assign bus.tx_ready    = (tx_level != LW'(DEPTH));
    assign bus.tx_level    = tx_level;
    assign bus.spi_enable  = enable_q;
    assign bus.spi_data_in = data_in_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_q;
endmodule
